// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric DRAM slot arbiter.
// The 12-phase line is split into three 4-phase slots A, B and C.
package oric_mem_pkg;

    typedef enum logic [1:0] {
        OwnCpu     = 2'd0,
        OwnVideo   = 2'd1,
        OwnRefresh = 2'd2,
        OwnDma     = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        SlotA = 2'd0,
        SlotB = 2'd1,
        SlotC = 2'd2
    } slot_e;

    localparam logic [3:0] SlotABase = 4'd0;
    localparam logic [3:0] SlotBBase = 4'd4;
    localparam logic [3:0] SlotCBase = 4'd8;
    localparam logic [3:0] PhaseLast = 4'd11;

    localparam logic [7:0] IO_PAGE       = 8'h03;
    localparam logic [2:0] DMA_BURST_MAX = 3'd4;

    function automatic slot_e slot_of(input logic [3:0] phase);
        if (phase >= SlotCBase) begin
            return SlotC;
        end else if (phase >= SlotBBase) begin
            return SlotB;
        end
        return SlotA;
    endfunction

endpackage

// File: rtl/oric_dram_arbiter_if.sv
// Bus bundle between the DRAM arbiter and the rest of the machine.
// The arbiter side uses the slave modport.
interface oric_dram_arbiter_if;

    logic        vid_en;
    logic [15:0] vid_addr;
    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic        nMAP;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_rnw;

    logic [7:0]  RC;
    logic        RAS;
    logic        CAS;
    logic        WE;
    logic        PHI;
    logic        RDY;
    logic        dma_ack;
    logic        vid_strobe;
    logic [1:0]  owner;

    modport master (
        output vid_en, vid_addr, cpu_addr, cpu_rnw, nMAP, dma_req, dma_addr, dma_rnw,
        input  RC, RAS, CAS, WE, PHI, RDY, dma_ack, vid_strobe, owner
    );

    modport slave (
        input  vid_en, vid_addr, cpu_addr, cpu_rnw, nMAP, dma_req, dma_addr, dma_rnw,
        output RC, RAS, CAS, WE, PHI, RDY, dma_ack, vid_strobe, owner
    );

endinterface

// File: rtl/oric_slot_timer.sv
// Free-running 12-phase line counter with current and next-phase slot decodes.
// Next-phase decodes let the arbiter register its outputs aligned to the phase.
module oric_slot_timer
    import oric_mem_pkg::*;
(
    input  logic       CLK,
    input  logic       nRESET,
    output logic [1:0] p_o,
    output logic [1:0] nxt_p_o,
    output slot_e      nxt_slot_o
);

    logic [3:0] phase_q, phase_d;

    always_comb begin
        phase_d = (phase_q == PhaseLast) ? SlotABase : phase_q + 4'd1;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            phase_q <= SlotABase;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign p_o        = phase_q[1:0];
    assign nxt_p_o    = phase_d[1:0];
    assign nxt_slot_o = slot_of(phase_d);

endmodule

// File: rtl/oric_dram_arbiter.sv
// Oric DRAM arbiter: assigns video/refresh/CPU/DMA owners per slot and
// generates RAS/CAS/WE, the multiplexed row/column address and CPU handshakes.
module oric_dram_arbiter
    import oric_mem_pkg::*;
(
    input  logic              CLK,
    input  logic              nRESET,
    oric_dram_arbiter_if.slave bus_io
);

    logic [1:0] p, nxt_p;
    slot_e      nxt_slot;

    oric_slot_timer u_timer (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .p_o        (p),
        .nxt_p_o    (nxt_p),
        .nxt_slot_o (nxt_slot)
    );

    owner_e     owner_q, owner_d, owner_new;
    logic [2:0] burst_q, burst_d;
    logic [6:0] row_q, row_d;
    logic       ras_q, ras_d, cas_q, cas_d, we_q, we_d, phi_q, phi_d;
    logic       rdy_q, rdy_d, ack_q, ack_d, vstr_q, vstr_d;
    logic       grant, active, cpu_block, writes;
    logic [15:0] addr;

    always_comb begin
        grant     = bus_io.dma_req && bus_io.cpu_rnw && (burst_q < DMA_BURST_MAX);
        cpu_block = (bus_io.cpu_addr[15:8] == IO_PAGE) ||
                    ((bus_io.cpu_addr[15:14] == 2'b11) && bus_io.nMAP);

        if (nxt_slot == SlotC) begin
            owner_new = grant ? OwnDma : OwnCpu;
        end else begin
            owner_new = bus_io.vid_en ? OwnVideo : OwnRefresh;
        end
        owner_d = (nxt_p == 2'd0) ? owner_new : owner_q;

        burst_d = burst_q;
        if ((nxt_p == 2'd0) && (nxt_slot == SlotC)) begin
            burst_d = grant ? burst_q + 3'd1 : 3'd0;
        end

        row_d = row_q;
        if ((owner_q == OwnRefresh) && (p == 2'd3)) begin
            row_d = row_q + 7'd1;
        end

        unique case (owner_d)
            OwnCpu:  writes = !bus_io.cpu_rnw;
            OwnDma:  writes = !bus_io.dma_rnw;
            default: writes = 1'b0;
        endcase

        // A CPU owner outside slot C only happens in the slot following reset; keep it idle.
        active = !((owner_d == OwnCpu) && (nxt_slot != SlotC));
        ras_d  = active && (nxt_p != 2'd0);
        cas_d  = active && nxt_p[1] && (owner_d != OwnRefresh) &&
                 !((owner_d == OwnCpu) && cpu_block);
        we_d   = cas_d && writes;
        phi_d  = (nxt_slot == SlotC);
        rdy_d  = (owner_d != OwnDma);
        ack_d  = (owner_d == OwnDma) && (nxt_p == 2'd3);
        vstr_d = (owner_d == OwnVideo) && (nxt_p == 2'd3);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            owner_q <= OwnCpu;
            burst_q <= 3'd0;
            row_q   <= 7'd0;
            ras_q   <= 1'b0;
            cas_q   <= 1'b0;
            we_q    <= 1'b0;
            phi_q   <= 1'b0;
            rdy_q   <= 1'b1;
            ack_q   <= 1'b0;
            vstr_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            row_q   <= row_d;
            ras_q   <= ras_d;
            cas_q   <= cas_d;
            we_q    <= we_d;
            phi_q   <= phi_d;
            rdy_q   <= rdy_d;
            ack_q   <= ack_d;
            vstr_q  <= vstr_d;
        end
    end

    always_comb begin
        addr = 16'h0000;
        unique case (owner_q)
            OwnCpu:   addr = bus_io.cpu_addr;
            OwnVideo: addr = bus_io.vid_addr;
            OwnDma:   addr = bus_io.dma_addr;
            default:  addr = 16'h0000;
        endcase
    end

    assign bus_io.RC         = (owner_q == OwnRefresh) ? {1'b0, row_q} :
                               (p[1] ? addr[7:0] : addr[15:8]);
    assign bus_io.RAS        = ras_q;
    assign bus_io.CAS        = cas_q;
    assign bus_io.WE         = we_q;
    assign bus_io.PHI        = phi_q;
    assign bus_io.RDY        = rdy_q;
    assign bus_io.dma_ack    = ack_q;
    assign bus_io.vid_strobe = vstr_q;
    assign bus_io.owner      = owner_q;

endmodule

// File: tb/tb_oric_dram_arbiter.sv
// Directed bench for oric_dram_arbiter; tracks the line phase by counting clocks
// from reset release and samples outputs on the falling edge.
module tb_oric_dram_arbiter;

    logic CLK = 1'b0;
    logic nRESET = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ph = 0;

    oric_dram_arbiter_if bus ();

    oric_dram_arbiter dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus_io (bus)
    );

    always #42 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        ph = (ph == 11) ? 0 : ph + 1;
    endtask

    task automatic run_to(input int target);
        while (ph != target) tick();
    endtask

    task automatic next_line();
        tick();
        run_to(0);
    endtask

    // Order: RDY RAS CAS WE PHI dma_ack vid_strobe owner[1:0]
    function automatic logic [8:0] ctl();
        return {bus.RDY, bus.RAS, bus.CAS, bus.WE, bus.PHI, bus.dma_ack, bus.vid_strobe,
                bus.owner};
    endfunction

    task automatic do_reset();
        nRESET = 1'b0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        ph = 0;
    endtask

    task automatic test_reset();
        bus.vid_en = 1'b0; bus.vid_addr = 16'h0000; bus.cpu_addr = 16'h1234;
        bus.cpu_rnw = 1'b1; bus.nMAP = 1'b1; bus.dma_req = 1'b0;
        bus.dma_addr = 16'h0000; bus.dma_rnw = 1'b1;
        nRESET = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ctl() !== 9'b1_0000_00_00) begin
            failures++;
            $display("FAIL reset_hold got=%b want=100000000", ctl());
        end
        nRESET = 1'b1;
        ph = 0;
        checks++;
        if (ctl() !== 9'b1_0000_00_00) begin
            failures++;
            $display("FAIL reset_release got=%b want=100000000", ctl());
        end
    endtask

    task automatic test_idle_refresh();
        logic [6:0] row;
        logic       exp_ras;
        bus.vid_en = 1'b0; bus.dma_req = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_rnw = 1'b1;
        do_reset();
        row = 7'd0;
        for (int c = 0; c < 12 * 66; c++) begin
            exp_ras = (ph % 4) != 0;
            if (c < 4) begin
                checks++;
                if (bus.CAS !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_first_slot_cas ph=%0d got=%b want=0", ph, bus.CAS);
                end
            end else if (ph < 8) begin
                checks++;
                if (bus.owner !== 2'd2 || bus.RC !== {1'b0, row} || bus.CAS !== 1'b0 ||
                    bus.WE !== 1'b0 || bus.RAS !== exp_ras) begin
                    failures++;
                    $display("FAIL idle_refresh c=%0d ph=%0d got owner=%0d rc=%h cas=%b we=%b ras=%b want owner=2 rc=%h cas=0 we=0 ras=%b",
                             c, ph, bus.owner, bus.RC, bus.CAS, bus.WE, bus.RAS, {1'b0, row},
                             exp_ras);
                end
                if (ph % 4 == 3) row = row + 7'd1;
            end
            tick();
        end
    endtask

    task automatic test_video();
        logic [7:0] exp_rc;
        logic       exp_vs, exp_cas;
        bus.vid_en = 1'b1; bus.vid_addr = 16'hBB80;
        next_line();
        for (int c = 0; c < 12; c++) begin
            if (ph < 8) begin
                exp_rc  = (ph % 4 < 2) ? 8'hBB : 8'h80;
                exp_vs  = (ph == 3) || (ph == 7);
                exp_cas = (ph % 4) >= 2;
                checks++;
                if (bus.owner !== 2'd1 || bus.RC !== exp_rc || bus.vid_strobe !== exp_vs ||
                    bus.CAS !== exp_cas || bus.WE !== 1'b0) begin
                    failures++;
                    $display("FAIL video ph=%0d got owner=%0d rc=%h vs=%b cas=%b we=%b want owner=1 rc=%h vs=%b cas=%b we=0",
                             ph, bus.owner, bus.RC, bus.vid_strobe, bus.CAS, bus.WE, exp_rc,
                             exp_vs, exp_cas);
                end
            end else begin
                checks++;
                if (bus.vid_strobe !== 1'b0) begin
                    failures++;
                    $display("FAIL video_strobe_slot_c ph=%0d got=%b want=0", ph, bus.vid_strobe);
                end
            end
            tick();
        end
    endtask

    task automatic test_dma_burst();
        logic exp_dma;
        bus.vid_en = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h1234;
        bus.dma_addr = 16'h5A3C; bus.dma_rnw = 1'b1;
        run_to(0);
        bus.dma_req = 1'b1;
        for (int line = 0; line < 10; line++) begin
            exp_dma = (line % 5) != 4;
            run_to(7);
            checks++;
            if (bus.RDY !== 1'b1) begin
                failures++;
                $display("FAIL dma_rdy_ph7 line=%0d got=%b want=1", line, bus.RDY);
            end
            tick();
            checks++;
            if (bus.owner !== (exp_dma ? 2'd3 : 2'd0) || bus.RDY !== !exp_dma ||
                bus.RC !== (exp_dma ? 8'h5A : 8'h12)) begin
                failures++;
                $display("FAIL dma_slot_start line=%0d got owner=%0d rdy=%b rc=%h want owner=%0d rdy=%b rc=%h",
                         line, bus.owner, bus.RDY, bus.RC, exp_dma ? 3 : 0, !exp_dma,
                         exp_dma ? 8'h5A : 8'h12);
            end
            run_to(10);
            checks++;
            if (bus.dma_ack !== 1'b0 || bus.RC !== (exp_dma ? 8'h3C : 8'h34)) begin
                failures++;
                $display("FAIL dma_ph10 line=%0d got ack=%b rc=%h want ack=0 rc=%h", line,
                         bus.dma_ack, bus.RC, exp_dma ? 8'h3C : 8'h34);
            end
            tick();
            checks++;
            if (bus.dma_ack !== exp_dma || bus.RDY !== !exp_dma) begin
                failures++;
                $display("FAIL dma_ph11 line=%0d got ack=%b rdy=%b want ack=%b rdy=%b", line,
                         bus.dma_ack, bus.RDY, exp_dma, !exp_dma);
            end
            tick();
            checks++;
            if (bus.RDY !== 1'b1 || bus.dma_ack !== 1'b0) begin
                failures++;
                $display("FAIL dma_ph0 line=%0d got rdy=%b ack=%b want rdy=1 ack=0", line,
                         bus.RDY, bus.dma_ack);
            end
        end
    endtask

    task automatic test_write_no_grant();
        bus.dma_req = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 16'h2345; bus.nMAP = 1'b1;
        run_to(0);
        run_to(8);
        checks++;
        if (bus.owner !== 2'd0 || bus.RDY !== 1'b1 || bus.WE !== 1'b0 || bus.PHI !== 1'b1) begin
            failures++;
            $display("FAIL wr_ph8 got owner=%0d rdy=%b we=%b phi=%b want owner=0 rdy=1 we=0 phi=1",
                     bus.owner, bus.RDY, bus.WE, bus.PHI);
        end
        tick();
        checks++;
        if (bus.WE !== 1'b0 || bus.RAS !== 1'b1) begin
            failures++;
            $display("FAIL wr_ph9 got we=%b ras=%b want we=0 ras=1", bus.WE, bus.RAS);
        end
        tick();
        checks++;
        if (bus.WE !== 1'b1 || bus.CAS !== 1'b1 || bus.RC !== 8'h45) begin
            failures++;
            $display("FAIL wr_ph10 got we=%b cas=%b rc=%h want we=1 cas=1 rc=45", bus.WE,
                     bus.CAS, bus.RC);
        end
        tick();
        checks++;
        if (bus.WE !== 1'b1 || bus.RDY !== 1'b1 || bus.dma_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_ph11 got we=%b rdy=%b ack=%b want we=1 rdy=1 ack=0", bus.WE,
                     bus.RDY, bus.dma_ack);
        end
    endtask

    task automatic test_io_rom();
        logic [15:0] addrs [3] = '{16'h0300, 16'hC000, 16'hC000};
        logic        nmaps [3] = '{1'b1, 1'b1, 1'b0};
        logic        cases [3] = '{1'b0, 1'b0, 1'b1};
        bus.dma_req = 1'b0; bus.cpu_rnw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_to(0);
            bus.cpu_addr = addrs[i];
            bus.nMAP = nmaps[i];
            run_to(9);
            checks++;
            if (bus.RAS !== 1'b1 || bus.CAS !== 1'b0) begin
                failures++;
                $display("FAIL iorom_ph9 case=%0d got ras=%b cas=%b want ras=1 cas=0", i,
                         bus.RAS, bus.CAS);
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                checks++;
                if (bus.CAS !== cases[i] || bus.RAS !== 1'b1 || bus.WE !== 1'b0) begin
                    failures++;
                    $display("FAIL iorom_cas case=%0d ph=%0d got cas=%b ras=%b we=%b want cas=%b ras=1 we=0",
                             i, ph, bus.CAS, bus.RAS, bus.WE, cases[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_dma();
        bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'h1234; bus.nMAP = 1'b1; bus.vid_en = 1'b0;
        bus.dma_req = 1'b1;
        run_to(0);
        run_to(9);
        checks++;
        if (bus.owner !== 2'd3 || bus.RDY !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_dma got owner=%0d rdy=%b want owner=3 rdy=0", bus.owner,
                     bus.RDY);
        end
        nRESET = 1'b0;
        #1;
        checks++;
        if (ctl() !== 9'b1_0000_00_00) begin
            failures++;
            $display("FAIL rst_mid_dma got=%b want=100000000", ctl());
        end
        bus.dma_req = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
        ph = 0;
        run_to(2);
        checks++;
        if (bus.CAS !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_ph2 got cas=%b want 0", bus.CAS);
        end
        run_to(4);
        checks++;
        if (bus.owner !== 2'd2) begin
            failures++;
            $display("FAIL rst_after_ph4 got owner=%0d want 2", bus.owner);
        end
        run_to(8);
        checks++;
        if (bus.owner !== 2'd0 || bus.PHI !== 1'b1 || bus.RDY !== 1'b1) begin
            failures++;
            $display("FAIL rst_after_ph8 got owner=%0d phi=%b rdy=%b want owner=0 phi=1 rdy=1",
                     bus.owner, bus.PHI, bus.RDY);
        end
        run_to(10);
        checks++;
        if (bus.CAS !== 1'b1) begin
            failures++;
            $display("FAIL rst_after_ph10 got cas=%b want 1", bus.CAS);
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_video();
        test_dma_burst();
        test_write_no_grant();
        test_io_rom();
        test_reset_mid_dma();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
